// File: rtl/led_pattern_ctrl.sv
// Pattern scheduler for the 4-LED bank: tick counter, queued mode requests,
// and blink / run-left / run-right / bounce pattern generation.
module led_pattern_ctrl #(
  parameter int unsigned      CNT_W   = 25,
  parameter logic [CNT_W-1:0] CNT_MAX = 25'd24_999_999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_req,
  input  logic [1:0] mode_sel,
  input  logic       pause,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       pend,
  output logic       tick
);

  typedef enum logic [1:0] {
    BLINK  = 2'd0,
    RUN_L  = 2'd1,
    RUN_R  = 2'd2,
    BOUNCE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_L = 1'b0,
    DIR_R = 1'b1
  } dir_t;

  logic [CNT_W-1:0] count, count_n;
  logic [3:0]       led_q, led_n;
  mode_t            cur_mode, mode_n;
  mode_t            pend_mode, pend_mode_n;
  logic             pend_q, pend_n;
  logic             tick_q;
  dir_t             dir, dir_n;
  logic             step;
  logic             led_onehot;

  function automatic logic [3:0] start_pat(input mode_t m);
    case (m)
      BLINK:   start_pat = 4'b1111;
      RUN_L:   start_pat = 4'b0001;
      RUN_R:   start_pat = 4'b1000;
      default: start_pat = 4'b0001;
    endcase
  endfunction

  assign step = (count == CNT_MAX) && !pause;

  always_comb begin
    led_onehot = 1'b0;
    case (led_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: led_onehot = 1'b1;
      default:                            led_onehot = 1'b0;
    endcase
  end

  always_comb begin
    count_n = count;
    if (!pause) begin
      if (count == CNT_MAX) count_n = '0;
      else                  count_n = count + 1'b1;
    end
  end

  // A request arriving on a step edge is latched while the step itself
  // still consumes the previously registered pend/pend_mode.
  always_comb begin
    pend_n      = pend_q;
    pend_mode_n = pend_mode;
    if (mode_req) begin
      pend_n      = 1'b1;
      pend_mode_n = mode_t'(mode_sel);
    end else if (step) begin
      pend_n = 1'b0;
    end
  end

  always_comb begin
    led_n  = led_q;
    mode_n = cur_mode;
    dir_n  = dir;
    if (step) begin
      if (pend_q) begin
        mode_n = pend_mode;
        led_n  = start_pat(pend_mode);
        if (pend_mode == BOUNCE) dir_n = DIR_L;
      end else if (cur_mode != BLINK && !led_onehot) begin
        // Only reachable from the all-lit reset value.
        led_n = start_pat(cur_mode);
        if (cur_mode == BOUNCE) dir_n = DIR_L;
      end else begin
        case (cur_mode)
          BLINK: led_n = ~led_q;
          RUN_L: led_n = {led_q[2:0], led_q[3]};
          RUN_R: led_n = {led_q[0], led_q[3:1]};
          default: begin
            if (dir == DIR_L) begin
              led_n = {led_q[2:0], 1'b0};
              if (led_n == 4'b1000) dir_n = DIR_R;
            end else begin
              led_n = {1'b0, led_q[3:1]};
              if (led_n == 4'b0001) dir_n = DIR_L;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      led_q     <= 4'b1111;
      cur_mode  <= BLINK;
      pend_q    <= 1'b0;
      pend_mode <= BLINK;
      tick_q    <= 1'b0;
      dir       <= DIR_L;
    end else begin
      count     <= count_n;
      led_q     <= led_n;
      cur_mode  <= mode_n;
      pend_q    <= pend_n;
      pend_mode <= pend_mode_n;
      tick_q    <= step;
      dir       <= dir_n;
    end
  end

  assign led  = led_q;
  assign mode = cur_mode;
  assign pend = pend_q;
  assign tick = tick_q;

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Pattern scheduler for the 4-LED bank. It sits between the key/command front end and the LED pins, and owns the tick counter and the pattern state. It supports four display modes: blink, run-left, run-right and bounce. Mode-change requests are queued and take effect only on a tick boundary, so a pattern step is never cut short.

## Interface
- CNT_W, 25, width of the tick counter
- CNT_MAX, 25'd24_999_999, terminal count; tick period = CNT_MAX+1 clk cycles; must be >= 1

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- mode_req  in  1  single-cycle request strobe; mode_sel sampled with it
- mode_sel  in  2  requested mode: 0 BLINK, 1 RUN_L, 2 RUN_R, 3 BOUNCE
- pause  in  1  level; while high, the counter and pattern freeze
- led  out  4  LED drive, 1 = lit
- mode  out  2  currently active mode
- pend  out  1  a mode request is queued and not yet applied
- tick  out  1  one-cycle pulse, high in the cycle after each pattern update

## Operation
- Reset values (while rst low):
  - count = 0, led = 4'b1111, mode = 0 (BLINK)
  - pend = 0, pend_mode = 0, tick = 0, dir = left
- Counter:
  - If pause = 0: when count == CNT_MAX, count wraps to 0; otherwise count increments.
  - If pause = 1: count holds.
- step = (count == CNT_MAX) && !pause. This is internal and combinational.
- Queue, updated every cycle:
  - If mode_req = 1: pend <= 1 and pend_mode <= mode_sel. A later request overwrites an earlier one.
  - Else if step: pend <= 0.
  - Else: hold.
- On step with pend = 1 (the registered value), the queued mode is applied:
  - mode <= pend_mode.
  - led <= start pattern: BLINK 1111, RUN_L 0001, RUN_R 1000, BOUNCE 0001 with dir <= left.
  - A request for the already-active mode still restarts its pattern.
- On step with pend = 0, led advances one position in the current mode:
  - BLINK: led <= ~led.
  - RUN_L: rotate left, 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  - RUN_R: rotate right, 1000 -> 0100 -> 0010 -> 0001 -> 1000.
  - BOUNCE, dir left: shift left; a result of 1000 sets dir <= right.
  - BOUNCE, dir right: shift right; a result of 0001 sets dir <= left.
  - BOUNCE sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001 (period 6).
- If led is not one-hot in RUN_L, RUN_R or BOUNCE (possible only through the reset value), the next step loads that mode's start pattern.
- No step: led, mode and dir hold.
- tick <= step, registered.

## Timing
- First step after rst deasserts: on the (CNT_MAX+1)-th rising clk edge, provided pause stays low.
- Pattern update: led and mode change on the same edge at which count wraps to 0. tick is high for the one cycle that follows that edge.
- Request latency: pend goes high on the edge after mode_req. The mode is applied on the next step edge after that, so worst case is CNT_MAX+1 cycles.
- mode_req in the same cycle as step:
  - The step uses the old registered pend and pend_mode. If pend was already 1, the old queued mode is applied.
  - The new request is latched, pend stays 1, and it applies on the following step.
- pause:
  - Takes effect on the first edge it is sampled high; no step and no tick while it is high.
  - Requests are still queued during pause.
  - After pause drops, counting resumes from the held count value.
- Asynchronous reset mid-operation: every register returns to its reset value immediately, without waiting for a clk edge. Any queued request is lost.

## Test plan
Run all scenarios with CNT_MAX = 3, i.e. a 4-cycle period.
- Reset and blink: hold rst low for 5 cycles -> led = 1111, mode = 0, pend = 0, tick = 0. Release rst -> led = 0000 on edge 4, tick high in cycle 5; led = 1111 on edge 8.
- Mode change: pulse mode_req with sel = 1 at count = 1 -> pend = 1 on the next edge. At the next wrap: led = 0001, mode = 1, pend = 0. Following steps: 0010, 0100, 1000, 0001.
- Bounce: request sel = 3 -> successive steps give led = 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- Pause: assert pause at count = 2 for 10 cycles -> count, led and mode are constant and tick = 0. Release pause -> the next step occurs 2 cycles later.
- Request ordering:
  - Request sel = 2, then sel = 1, before one wrap -> mode becomes 1 with led = 0001.
  - Request sel = 3 in the same cycle as a step while pend holds 2 -> mode becomes 2 (led = 1000) and pend stays 1. One step later: mode = 3, led = 0001.
- Async reset: in RUN_R, drop rst between clk edges -> led = 1111, mode = 0, pend = 0 before the next edge. Normal blink resumes after release.
